move_stepper: RTL and testbench
===============================

MOVE_STEPPER -- requirements
Module: move_stepper

Interface
REQ-001 Parameter START_X, default 4'd0, start column.
REQ-002 Parameter START_Y, default 4'd0, start row.
REQ-003 Parameter GOAL_X, default 4'd15, goal column.
REQ-004 Parameter GOAL_Y, default 4'd15, goal row.
REQ-005 Parameter MAX_MOVES, default 8'd255, committed-move budget.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 cmd_valid  input  1  move command offered.
REQ-009 cmd_op  input  2  opcode: 00 up (y-1), 01 right (x+1), 10 left (x-1), 11 down (y+1).
REQ-010 cmd_ready  output  1  block can accept a command this cycle.
REQ-011 mem_rd_en  output  1  maze map read strobe.
REQ-012 mem_addr  output  8  map address {y[3:0], x[3:0]}.
REQ-013 mem_rd_data  input  1  map bit, 1 = wall; valid exactly one cycle after mem_rd_en.
REQ-014 pos_x / pos_y  output  4 each  committed position.
REQ-015 move_count  output  8  number of committed moves.
REQ-016 edge_hit  output  1  one-cycle pulse: move rejected by grid-edge clamp.
REQ-017 wall_hit  output  1  one-cycle pulse: move rejected by wall.
REQ-018 done  output  1  level: run finished (goal or budget).
REQ-019 goal_reached  output  1  level: the run finished at GOAL_X/GOAL_Y.

Function
REQ-020 The block SHALL implement states IDLE, READ, CHECK, DONE.
REQ-021 cmd_ready SHALL be 1 only in IDLE.
REQ-022 Handshake: a command SHALL be accepted on an edge where cmd_valid and cmd_ready are both 1.
REQ-023 The candidate position SHALL be computed from pos_x/pos_y and cmd_op with clamping at 0 and 15, with no wrap-around.
REQ-024 If the candidate equals the current position (edge clamp), the accept edge SHALL keep IDLE and assert edge_hit for the next cycle.
  - No memory read is issued.
  - move_count is unchanged.
REQ-025 Otherwise, the accept edge SHALL register the candidate and go to READ.
REQ-026 In READ, mem_rd_en SHALL be 1 and mem_addr SHALL be {cand_y, cand_x}. READ always goes to CHECK.
  - In all other states, mem_rd_en is 0 and mem_addr holds {pos_y, pos_x}.
REQ-027 On leaving CHECK with mem_rd_data=1, the block SHALL pulse wall_hit for one cycle and return to IDLE; position is unchanged.
REQ-028 On leaving CHECK with mem_rd_data=0, the block SHALL commit the candidate to pos_x/pos_y and increment move_count.
REQ-029 Latency: a successful move SHALL be visible on pos_x/pos_y 3 cycles after the accept edge; the next command can be accepted in that same cycle.
REQ-030 After a commit, the next state SHALL be DONE if the new position equals the goal or the new move_count equals MAX_MOVES; otherwise it SHALL be IDLE.
  - If both conditions are true, goal_reached = 1.
REQ-031 In DONE, done SHALL be 1, cmd_ready SHALL be 0, and all commands are ignored until rst.
REQ-032 cmd_op SHALL be sampled only at the accept edge; changes during READ/CHECK have no effect.
REQ-033 move_count SHALL never wrap, since DONE is entered at MAX_MOVES.

Reset
REQ-034 On an rst edge the block SHALL enter IDLE from any state, including mid-READ/CHECK, and discard any pending candidate.
REQ-035 Reset values: pos = (START_X, START_Y), move_count = 0, edge_hit = wall_hit = done = goal_reached = mem_rd_en = 0.
  - cmd_ready is 1 in the first cycle after reset.
REQ-036 If START equals GOAL, the block SHALL still wait in IDLE; the goal check applies only on commit.

Structure
REQ-037 The opcode encodings, state enum and the GRID_MAX=15 constant SHALL live in the shared package maze_pkg.
REQ-038 The block SHALL instantiate one move_translator sub-module to compute the candidate; it SHALL NOT duplicate the clamping logic.

Verification
REQ-039 Reset at (0,0); send op 00 -> edge_hit pulses 1 cycle, no mem_rd_en, pos stays (0,0), move_count 0.
REQ-040 From (0,0), op 01 with map bit (1,0)=0 -> mem_addr 8'h01 in READ, pos=(1,0) 3 cycles after accept, move_count 1.
REQ-041 From (1,0), op 11 with map bit at address 8'h11 = 1 -> wall_hit pulse, pos stays (1,0), cmd_ready back to 1 next cycle.
REQ-042 GOAL=(2,0); moves 01, 01 on an empty map -> done=1, goal_reached=1, a further cmd_valid stays unaccepted, move_count 2.
REQ-043 MAX_MOVES=3; moves 01, 10, 01 on an empty map -> done=1, goal_reached=0 after the third commit.
REQ-044 Assert rst during CHECK of a legal move -> pos returns to START, no commit, move_count 0, IDLE next cycle.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared definitions for the maze move stepper: grid limit, move opcodes,
// controller states and the map address packing helper.
package maze_pkg;

    localparam logic [3:0] GRID_MAX = 4'd15;

    typedef enum logic [1:0] {
        OP_UP    = 2'b00,
        OP_RIGHT = 2'b01,
        OP_LEFT  = 2'b10,
        OP_DOWN  = 2'b11
    } move_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Map word address for a cell: row in the upper nibble, column in the lower.
    function automatic logic [7:0] map_addr(input logic [3:0] x, input logic [3:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/move_translator.sv
// Candidate position for one move opcode, clamped to the grid with no
// wrap-around. Flags when the clamp leaves the position unchanged.
module move_translator
    import maze_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic [1:0] op,
    output logic [3:0] cand_x,
    output logic [3:0] cand_y,
    output logic       clamped
);

    // Step one cell in the requested direction unless already on that edge.
    always_comb begin
        cand_x = x;
        cand_y = y;
        case (op)
            OP_UP:    if (y != '0)       cand_y = y - 4'd1;
            OP_RIGHT: if (x != GRID_MAX) cand_x = x + 4'd1;
            OP_LEFT:  if (x != '0)       cand_x = x - 4'd1;
            OP_DOWN:  if (y != GRID_MAX) cand_y = y + 4'd1;
            default: begin
                cand_x = x;
                cand_y = y;
            end
        endcase
        clamped = (cand_x == x) && (cand_y == y);
    end

endmodule

// File: rtl/move_stepper.sv
// Maze walker: accepts move commands, checks the target cell against an
// external map with one-cycle read latency, and commits legal moves until
// the goal is reached or the move budget is spent.
module move_stepper
    import maze_pkg::*;
#(
    parameter logic [3:0] START_X   = 4'd0,
    parameter logic [3:0] START_Y   = 4'd0,
    parameter logic [3:0] GOAL_X    = 4'd15,
    parameter logic [3:0] GOAL_Y    = 4'd15,
    parameter logic [7:0] MAX_MOVES = 8'd255
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    output logic       cmd_ready,
    output logic       mem_rd_en,
    output logic [7:0] mem_addr,
    input  logic       mem_rd_data,
    output logic [3:0] pos_x,
    output logic [3:0] pos_y,
    output logic [7:0] move_count,
    output logic       edge_hit,
    output logic       wall_hit,
    output logic       done,
    output logic       goal_reached
);

    state_e     state;
    logic [3:0] cand_x;
    logic [3:0] cand_y;
    logic [3:0] next_x;
    logic [3:0] next_y;
    logic       clamped;
    logic       accept;
    logic [7:0] count_next;
    logic       at_goal;

    move_translator u_translator (
        .x       (pos_x),
        .y       (pos_y),
        .op      (cmd_op),
        .cand_x  (next_x),
        .cand_y  (next_y),
        .clamped (clamped)
    );

    assign cmd_ready  = (state == ST_IDLE);
    assign accept     = cmd_valid && cmd_ready;
    assign mem_rd_en  = (state == ST_READ);
    assign mem_addr   = (state == ST_READ) ? map_addr(cand_x, cand_y) : map_addr(pos_x, pos_y);
    assign done       = (state == ST_DONE);
    assign count_next = move_count + 8'd1;
    assign at_goal    = (cand_x == GOAL_X) && (cand_y == GOAL_Y);

    // Controller: accept, read the map cell, then commit or reject the move.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            pos_x        <= START_X;
            pos_y        <= START_Y;
            cand_x       <= START_X;
            cand_y       <= START_Y;
            move_count   <= '0;
            edge_hit     <= 1'b0;
            wall_hit     <= 1'b0;
            goal_reached <= 1'b0;
        end else begin
            edge_hit <= 1'b0;
            wall_hit <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (clamped) begin
                            edge_hit <= 1'b1;
                        end else begin
                            cand_x <= next_x;
                            cand_y <= next_y;
                            state  <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (mem_rd_data) begin
                        wall_hit <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        pos_x      <= cand_x;
                        pos_y      <= cand_y;
                        move_count <= count_next;
                        if (at_goal || (count_next == MAX_MOVES)) begin
                            goal_reached <= at_goal;
                            state        <= ST_DONE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_stepper.sv
// Scoreboard bench for move_stepper: two instances (default parameters and a
// short-goal / small-budget variant) driven with directed and random moves.
module tb_move_stepper;

    typedef struct {
        int kind;   // 0 edge clamp, 1 wall, 2 commit
        int cyc;    // cycle in which the outcome must be visible
        int addr;   // expected map address during the read
        int x;
        int y;
        int cnt;
        bit dn;
        bit gl;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    logic       rst          [2];
    logic       cmd_valid    [2];
    logic [1:0] cmd_op       [2];
    logic       cmd_ready    [2];
    logic       mem_rd_en    [2];
    logic [7:0] mem_addr     [2];
    logic       mem_rd_data  [2];
    logic [3:0] pos_x        [2];
    logic [3:0] pos_y        [2];
    logic [7:0] move_count   [2];
    logic       edge_hit     [2];
    logic       wall_hit     [2];
    logic       done         [2];
    logic       goal_reached [2];

    int gx   [2] = '{15, 2};
    int gy   [2] = '{15, 0};
    int mmax [2] = '{255, 3};

    bit   maze [2][256];
    exp_t sbq  [2][$];

    // reference model state (advanced by the stimulus)
    int mx [2];
    int my [2];
    int mcnt [2];
    bit mdone [2];

    // monitor's view of committed state (advanced when outcomes are observed)
    int ox [2];
    int oy [2];
    int ocnt [2];
    bit odone [2];
    bit ogoal [2];

    move_stepper u_a (
        .clk(clk), .rst(rst[0]), .cmd_valid(cmd_valid[0]), .cmd_op(cmd_op[0]),
        .cmd_ready(cmd_ready[0]), .mem_rd_en(mem_rd_en[0]), .mem_addr(mem_addr[0]),
        .mem_rd_data(mem_rd_data[0]), .pos_x(pos_x[0]), .pos_y(pos_y[0]),
        .move_count(move_count[0]), .edge_hit(edge_hit[0]), .wall_hit(wall_hit[0]),
        .done(done[0]), .goal_reached(goal_reached[0])
    );

    move_stepper #(.GOAL_X(4'd2), .GOAL_Y(4'd0), .MAX_MOVES(8'd3)) u_b (
        .clk(clk), .rst(rst[1]), .cmd_valid(cmd_valid[1]), .cmd_op(cmd_op[1]),
        .cmd_ready(cmd_ready[1]), .mem_rd_en(mem_rd_en[1]), .mem_addr(mem_addr[1]),
        .mem_rd_data(mem_rd_data[1]), .pos_x(pos_x[1]), .pos_y(pos_y[1]),
        .move_count(move_count[1]), .edge_hit(edge_hit[1]), .wall_hit(wall_hit[1]),
        .done(done[1]), .goal_reached(goal_reached[1])
    );

    // Map memory: data valid one cycle after a read strobe, noise otherwise.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            mem_rd_data[i] <= mem_rd_en[i] ? maze[i][mem_addr[i]] : 1'($urandom);
    end

    function automatic void chk(input int i, input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s inst=%0d act=%0d exp=%0d cycle=%0d", name, i, act, expv, cyc);
        end
    endfunction

    // Monitor: pops expected outcomes as the DUT presents them and checks levels.
    always @(negedge clk) begin
        exp_t h;
        int   kind;
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) continue;
            if (sbq[i].size() > 0 && sbq[i][0].cyc < cyc) begin
                tests++;
                fails++;
                $display("FAIL missing_event inst=%0d act=none exp_kind=%0d exp_cycle=%0d",
                         i, sbq[i][0].kind, sbq[i][0].cyc);
                void'(sbq[i].pop_front());
            end
            if (mem_rd_en[i]) begin
                if (sbq[i].size() == 0 || sbq[i][0].kind == 0) begin
                    chk(i, "rd_en_unexpected", 1, 0);
                end else begin
                    chk(i, "rd_addr", int'(mem_addr[i]), sbq[i][0].addr);
                    chk(i, "rd_cycle", cyc, sbq[i][0].cyc - 2);
                end
            end
            if (edge_hit[i] || wall_hit[i] || int'(move_count[i]) != ocnt[i]) begin
                kind = edge_hit[i] ? 0 : (wall_hit[i] ? 1 : 2);
                if (sbq[i].size() == 0) begin
                    chk(i, "unexpected_event", kind, -1);
                end else begin
                    h = sbq[i].pop_front();
                    chk(i, "event_kind", kind, h.kind);
                    chk(i, "event_cycle", cyc, h.cyc);
                    if (h.kind == 2) begin
                        ox[i]   = h.x;
                        oy[i]   = h.y;
                        ocnt[i] = h.cnt;
                    end
                    odone[i] = h.dn;
                    ogoal[i] = h.gl;
                end
            end
            chk(i, "pos_x", int'(pos_x[i]), ox[i]);
            chk(i, "pos_y", int'(pos_y[i]), oy[i]);
            chk(i, "move_count", int'(move_count[i]), ocnt[i]);
            chk(i, "done", int'(done[i]), int'(odone[i]));
            chk(i, "goal_reached", int'(goal_reached[i]), int'(ogoal[i]));
            if (odone[i]) chk(i, "ready_in_done", int'(cmd_ready[i]), 0);
        end
    end

    task automatic do_reset(input int i);
        rst[i] = 1'b1;
        cmd_valid[i] = 1'b0;
        @(posedge clk); #1;
        rst[i] = 1'b0;
        sbq[i].delete();
        mx[i] = 0; my[i] = 0; mcnt[i] = 0; mdone[i] = 1'b0;
        ox[i] = 0; oy[i] = 0; ocnt[i] = 0; odone[i] = 1'b0; ogoal[i] = 1'b0;
        chk(i, "rst_ready", int'(cmd_ready[i]), 1);
        chk(i, "rst_pos_x", int'(pos_x[i]), 0);
        chk(i, "rst_pos_y", int'(pos_y[i]), 0);
        chk(i, "rst_count", int'(move_count[i]), 0);
        chk(i, "rst_flags", int'({edge_hit[i], wall_hit[i], done[i], goal_reached[i], mem_rd_en[i]}), 0);
    endtask

    // Offer one command when the DUT is ready; predict its outcome from grid rules.
    task automatic send(input int i, input int op);
        exp_t e;
        int   nx, ny, c;
        bit   acc;
        acc = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (cmd_ready[i]) begin
                acc = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!acc) begin
            chk(i, "ready_timeout", 0, 1);
            return;
        end
        cmd_valid[i] = 1'b1;
        cmd_op[i]    = 2'(op);
        c  = cyc;
        nx = mx[i];
        ny = my[i];
        case (op)
            0:       ny = ny - 1;
            1:       nx = nx + 1;
            2:       nx = nx - 1;
            default: ny = ny + 1;
        endcase
        e.x = mx[i]; e.y = my[i]; e.cnt = mcnt[i]; e.dn = 1'b0; e.gl = 1'b0; e.addr = 0;
        if (nx < 0 || nx > 15 || ny < 0 || ny > 15) begin
            e.kind = 0;
            e.cyc  = c + 1;
        end else begin
            e.addr = ny * 16 + nx;
            e.cyc  = c + 3;
            if (maze[i][e.addr]) begin
                e.kind = 1;
            end else begin
                e.kind = 2;
                mx[i] = nx; my[i] = ny; mcnt[i]++;
                e.x = nx; e.y = ny; e.cnt = mcnt[i];
                e.gl = (nx == gx[i] && ny == gy[i]);
                mdone[i] = e.gl || (mcnt[i] == mmax[i]);
                e.dn = mdone[i];
            end
        end
        sbq[i].push_back(e);
        @(posedge clk); #1;
        cmd_valid[i] = 1'b0;
        cmd_op[i]    = 2'($urandom);
    endtask

    task automatic wait_drain(input int i);
        for (int k = 0; k < 20; k++) begin
            if (sbq[i].size() == 0) break;
            @(posedge clk); #1;
        end
        if (sbq[i].size() != 0) chk(i, "drain_timeout", sbq[i].size(), 0);
    endtask

    // Hold a command on a finished block and confirm it is never taken.
    task automatic check_done(input int i);
        cmd_valid[i] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cmd_op[i] = 2'($urandom);
            @(posedge clk); #1;
            chk(i, "done_ignores_cmd", int'(cmd_ready[i]), 0);
        end
        cmd_valid[i] = 1'b0;
    endtask

    task automatic random_maze(input int i);
        for (int a = 0; a < 256; a++) maze[i][a] = ($urandom % 4 == 0);
    endtask

    function automatic int pick_op(input bit biased);
        int r;
        if (!biased) return int'($urandom % 4);
        r = int'($urandom % 8);
        if (r < 3) return 1;
        if (r < 6) return 3;
        return (r == 6) ? 0 : 2;
    endfunction

    initial begin
        rst = '{1'b1, 1'b1};
        cmd_valid = '{1'b0, 1'b0};
        cmd_op = '{2'b00, 2'b00};
        repeat (2) @(posedge clk);
        #1;
        do_reset(0);
        do_reset(1);

        // edge clamp at origin, legal step right, wall below
        send(0, 0);
        wait_drain(0);
        send(0, 1);
        wait_drain(0);
        maze[0][8'h11] = 1'b1;
        send(0, 3);
        wait_drain(0);
        chk(0, "ready_after_wall", int'(cmd_ready[0]), 1);

        // reset while the map check of a legal move is in flight
        maze[0][8'h11] = 1'b0;
        do_reset(0);
        send(0, 1);
        @(posedge clk); #1;
        do_reset(0);
        repeat (4) begin
            @(posedge clk); #1;
        end

        // random walks on the default-parameter instance
        for (int run = 0; run < 4; run++) begin
            random_maze(0);
            do_reset(0);
            for (int n = 0; n < 250; n++) begin
                if (mdone[0]) break;
                send(0, pick_op(run[0]));
            end
            wait_drain(0);
            if (mdone[0]) check_done(0);
        end

        // goal at (2,0) reached on the second move
        for (int a = 0; a < 256; a++) maze[1][a] = 1'b0;
        do_reset(1);
        send(1, 1);
        send(1, 1);
        wait_drain(1);
        check_done(1);
        chk(1, "goal_level", int'(goal_reached[1]), 1);
        chk(1, "goal_count", int'(move_count[1]), 2);

        // budget of three moves spent away from the goal
        do_reset(1);
        send(1, 1);
        send(1, 2);
        send(1, 1);
        wait_drain(1);
        check_done(1);
        chk(1, "budget_done", int'(done[1]), 1);
        chk(1, "budget_goal", int'(goal_reached[1]), 0);

        // short random runs on the small-budget instance
        for (int run = 0; run < 30; run++) begin
            random_maze(1);
            do_reset(1);
            for (int n = 0; n < 8; n++) begin
                if (mdone[1]) break;
                send(1, pick_op(1'b0));
            end
            wait_drain(1);
            if (mdone[1]) check_done(1);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
